spi_byte_rx: RTL and testbench

- Receive side of the serial link that the 3 MHz divided clock drives.
- Takes an externally generated sck, sdi and cs_n from a remote master or the sigrok pattern generator; all three are asynchronous to the 27 MHz system clock.
- Synchronises them into the clk domain and detects sck rising edges.
- Shifts in DATA_W-bit words and presents each word on a valid/ready output for the blink/LED logic or a FIFO.

---
 rtl/spi_byte_rx_if.sv | 8 +
 rtl/spi_byte_rx.sv | 76 +++++++
 tb/tb_spi_byte_rx.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/spi_byte_rx_if.sv
// spi_byte_rx_if: received-word valid/ready channel
interface spi_byte_rx_if #(parameter int DATA_W = 8);
  logic [DATA_W-1:0] rx_data;
  logic rx_valid;
  logic rx_ready;
  modport master (output rx_data, rx_valid, input rx_ready);
  modport slave (input rx_data, rx_valid, output rx_ready);
endinterface

// File: rtl/spi_byte_rx.sv
// spi_byte_rx: synchronises an external SPI master and delivers DATA_W-bit words on a valid/ready channel
module spi_byte_rx #(
  parameter int DATA_W = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sck,
  input  logic sdi,
  input  logic cs_n,
  spi_byte_rx_if.master rx,
  output logic frame_active,
  output logic overrun,
  output logic frame_err
);
  localparam int CW = $clog2(DATA_W + 1);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SHIFT = 1'b1;
  logic [SYNC_STAGES-1:0] sck_s, sdi_s, cs_s;
  logic sck_d, rise, done, last;
  logic [0:0] state;
  logic [CW-1:0] cnt;
  logic [DATA_W-1:0] sh, sh_nx;
  always_comb begin
    rise = sck_s[SYNC_STAGES-1] & ~sck_d;
    last = cnt == CW'(DATA_W - 1);
    sh_nx = MSB_FIRST ? {sh[DATA_W-2:0], sdi_s[SYNC_STAGES-1]} : {sdi_s[SYNC_STAGES-1], sh[DATA_W-1:1]};
    frame_active = state == SHIFT;
  end
  // done marks the cycle after the completing rise; sh holds the full word then
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sck_s <= '0;
      sdi_s <= '0;
      cs_s <= '1;
      sck_d <= 1'b0;
      state <= IDLE;
      cnt <= '0;
      sh <= '0;
      done <= 1'b0;
      rx.rx_data <= '0;
      rx.rx_valid <= 1'b0;
      overrun <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sck_s <= {sck_s[SYNC_STAGES-2:0], sck};
      sdi_s <= {sdi_s[SYNC_STAGES-2:0], sdi};
      cs_s <= {cs_s[SYNC_STAGES-2:0], cs_n};
      sck_d <= sck_s[SYNC_STAGES-1];
      done <= 1'b0;
      frame_err <= 1'b0;
      if (state == IDLE) begin
        if (!cs_s[SYNC_STAGES-1]) begin
          state <= SHIFT;
          cnt <= '0;
        end
      end else if (cs_s[SYNC_STAGES-1]) begin
        state <= IDLE;
        cnt <= '0;
        frame_err <= cnt != '0;
      end else if (rise) begin
        sh <= sh_nx;
        done <= last;
        cnt <= last ? '0 : cnt + 1'b1;
      end
      overrun <= done & rx.rx_valid & ~rx.rx_ready;
      if (done & (~rx.rx_valid | rx.rx_ready)) begin
        rx.rx_data <= sh;
        rx.rx_valid <= 1'b1;
      end else if (rx.rx_ready) begin
        rx.rx_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_spi_byte_rx.sv
// tb_spi_byte_rx: scoreboard bench driving an MSB-first and an LSB-first receiver from the same pins
module tb_spi_byte_rx;
  logic clk = 1'b0;
  logic rst_n, sck, sdi, cs_n;
  logic fa1, ov1, fe1, fa2, ov2, fe2;
  int checks = 0, errors = 0, cyc = 0, rise_cyc = 0;
  int ov_cnt = 0, fe_cnt = 0, vh_cnt = 0;
  int o0, f0, vh0;
  logic v1_prev = 1'b0;
  logic [7:0] q1[$], q2[$];
  spi_byte_rx_if #(.DATA_W(8)) b1 ();
  spi_byte_rx_if #(.DATA_W(8)) b2 ();
  assign b2.rx_ready = 1'b1;
  spi_byte_rx #(.DATA_W(8), .MSB_FIRST(1'b1), .SYNC_STAGES(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .sck(sck), .sdi(sdi), .cs_n(cs_n), .rx(b1.master),
    .frame_active(fa1), .overrun(ov1), .frame_err(fe1));
  spi_byte_rx #(.DATA_W(8), .MSB_FIRST(1'b0), .SYNC_STAGES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .sck(sck), .sdi(sdi), .cs_n(cs_n), .rx(b2.master),
    .frame_active(fa2), .overrun(ov2), .frame_err(fe2));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [7:0] rev(input logic [7:0] w);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = w[7-i];
    return r;
  endfunction
  always @(negedge clk) begin
    v1_prev <= b1.rx_valid;
    if (rst_n) begin
      if (b1.rx_valid && !v1_prev) chk("latency", 32'(cyc - rise_cyc), 32'd4);
      if (b1.rx_valid && b1.rx_ready) begin
        if (q1.size() == 0) chk("sb1_underflow", 32'(q1.size()), 32'd1);
        else chk("sb1_data", 32'(b1.rx_data), 32'(q1.pop_front()));
      end
      if (b2.rx_valid) begin
        if (q2.size() == 0) chk("sb2_underflow", 32'(q2.size()), 32'd1);
        else chk("sb2_data", 32'(b2.rx_data), 32'(q2.pop_front()));
      end
      ov_cnt <= ov_cnt + int'(ov1);
      fe_cnt <= fe_cnt + int'(fe1);
      vh_cnt <= vh_cnt + int'(b1.rx_valid);
    end
  end
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask
  task automatic send_bit(input logic b, input bit pulse);
    sdi = b;
    sck = 1'b0;
    tick(9);
    sck = 1'b1;
    rise_cyc = cyc;
    if (pulse) begin
      tick(3);
      b1.rx_ready = 1'b1;
      tick(1);
      b1.rx_ready = 1'b0;
      tick(5);
    end else tick(9);
  endtask
  task automatic send_byte(input logic [7:0] w, input bit push1, input bit pulse);
    if (push1) q1.push_back(w);
    q2.push_back(rev(w));
    for (int i = 0; i < 8; i++) send_bit(w[7-i], pulse && i == 7);
  endtask
  task automatic frame_start();
    cs_n = 1'b0;
    tick(9);
  endtask
  task automatic frame_end();
    sck = 1'b0;
    tick(9);
    cs_n = 1'b1;
    tick(9);
  endtask
  initial begin
    rst_n = 1'b0; sck = 1'b0; sdi = 1'b0; cs_n = 1'b1; b1.rx_ready = 1'b0;
    repeat (4) begin sck = ~sck; tick(1); end
    chk("rst_valid", 32'(b1.rx_valid), 32'd0);
    chk("rst_fa", 32'(fa1), 32'd0);
    rst_n = 1'b1;
    repeat (20) begin sck = ~sck; tick(3); end
    sck = 1'b0;
    tick(9);
    chk("idle_valid", 32'(b1.rx_valid), 32'd0);
    chk("idle_data", 32'(b1.rx_data), 32'h00);
    chk("idle_fa", 32'(fa1), 32'd0);
    chk("idle_ov", 32'(ov_cnt), 32'd0);
    chk("idle_fe", 32'(fe_cnt), 32'd0);
    b1.rx_ready = 1'b1;
    vh0 = vh_cnt;
    frame_start();
    chk("fa_on", 32'(fa1), 32'd1);
    send_byte(8'hA5, 1'b1, 1'b0);
    frame_end();
    chk("a5_valid_cycles", 32'(vh_cnt - vh0), 32'd1);
    chk("a5_data", 32'(b1.rx_data), 32'hA5);
    chk("fa_off", 32'(fa1), 32'd0);
    b1.rx_ready = 1'b0;
    o0 = ov_cnt;
    frame_start();
    send_byte(8'h3C, 1'b1, 1'b0);
    send_byte(8'hC3, 1'b0, 1'b0);
    send_byte(8'h7E, 1'b0, 1'b0);
    frame_end();
    chk("bp_data", 32'(b1.rx_data), 32'h3C);
    chk("bp_valid", 32'(b1.rx_valid), 32'd1);
    chk("bp_overrun", 32'(ov_cnt - o0), 32'd2);
    b1.rx_ready = 1'b1;
    tick(1);
    b1.rx_ready = 1'b0;
    @(negedge clk);
    chk("bp_fall", 32'(b1.rx_valid), 32'd0);
    o0 = ov_cnt;
    frame_start();
    send_byte(8'h11, 1'b1, 1'b0);
    send_byte(8'h22, 1'b1, 1'b1);
    chk("sim_valid", 32'(b1.rx_valid), 32'd1);
    chk("sim_data", 32'(b1.rx_data), 32'h22);
    chk("sim_overrun", 32'(ov_cnt - o0), 32'd0);
    frame_end();
    b1.rx_ready = 1'b1;
    tick(2);
    f0 = fe_cnt;
    vh0 = vh_cnt;
    frame_start();
    repeat (5) send_bit(1'b1, 1'b0);
    cs_n = 1'b1;
    tick(9);
    chk("fe_pulse", 32'(fe_cnt - f0), 32'd1);
    chk("fe_novalid", 32'(vh_cnt - vh0), 32'd0);
    sck = 1'b0;
    tick(9);
    frame_start();
    send_byte(8'h81, 1'b1, 1'b0);
    frame_end();
    chk("fe_next_data", 32'(b1.rx_data), 32'h81);
    chk("fe_once", 32'(fe_cnt - f0), 32'd1);
    f0 = fe_cnt;
    frame_start();
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    rst_n = 1'b0; cs_n = 1'b1; sck = 1'b0;
    tick(4);
    chk("mr_valid", 32'(b1.rx_valid), 32'd0);
    chk("mr_fa", 32'(fa1), 32'd0);
    rst_n = 1'b1;
    tick(9);
    frame_start();
    send_byte(8'h5A, 1'b1, 1'b0);
    frame_end();
    chk("mr_msb_data", 32'(b1.rx_data), 32'h5A);
    chk("mr_lsb_data", 32'(b2.rx_data), 32'h5A);
    chk("mr_no_fe", 32'(fe_cnt - f0), 32'd0);
    chk("sb1_left", 32'(q1.size()), 32'd0);
    chk("sb2_left", 32'(q2.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
